// File: rtl/cache_pkg.sv
// Shared types for the write-back cache controller: FSM state encoding and
// next-level memory operation codes.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        INSTALL,
        RESPOND
    } cache_state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/cache_controller_if.sv
// CPU-side request/response handshake of the cache controller.
// master = CPU, slave = cache controller.
interface cache_controller_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_err
    );
endinterface

// File: rtl/cache_perf_counters.sv
// Three saturating performance counters (hit / miss / writeback) driven by
// single-cycle increment strobes from the controller FSM.
module cache_perf_counters #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit_inc,
    input  logic             miss_inc,
    input  logic             wb_inc,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
);

    // Counters park at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (hit_inc && hit_cnt != '1)   hit_cnt  <= hit_cnt + CNT_W'(1);
            if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            if (wb_inc && wb_cnt != '1)     wb_cnt   <= wb_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Sequencing FSM for one direct-mapped write-back cache level: lookup,
// writeback, fill and install against an external metadata block.
module cache_controller
    import cache_pkg::*;
#(
    parameter int NUM_SETS  = 4,
    parameter int SET_SIZE  = 2,
    parameter int TAG_SIZE  = 30,
    parameter int READ_ONLY = 0,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    cache_controller_if.slave            cpu,
    output logic [SET_SIZE-1:0]          set,
    output logic [TAG_SIZE-1:0]          tag,
    input  logic                         valid_block_match,
    input  logic                         valid_dirty_bit,
    input  logic [TAG_SIZE-1:0]          selected_tag,
    output logic                         clear_selected_valid_bit,
    output logic                         finish_new_line_install,
    output logic                         clear_selected_dirty_bit,
    output logic                         set_selected_dirty_bit,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_we,
    output logic [TAG_SIZE+SET_SIZE-1:0] mem_req_addr,
    input  logic                         mem_resp_valid,
    output logic [CNT_W-1:0]             hit_cnt,
    output logic [CNT_W-1:0]             miss_cnt,
    output logic [CNT_W-1:0]             wb_cnt
);

    localparam bit RO = (READ_ONLY != 0);

    if (NUM_SETS != (1 << SET_SIZE)) begin : g_bad_sets
        $error("NUM_SETS must equal 2**SET_SIZE");
    end

    cache_state_t state;
    logic         we_q;
    logic         ro_write;
    logic         hit_inc;
    logic         miss_inc;
    logic         wb_inc;

    assign ro_write = RO && we_q;
    assign hit_inc  = (state == LOOKUP) && !ro_write && valid_block_match;
    assign miss_inc = (state == LOOKUP) && !ro_write && !valid_block_match;
    assign wb_inc   = !RO && (state == WB_WAIT) && mem_resp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= IDLE;
            we_q                     <= 1'b0;
            set                      <= '0;
            tag                      <= '0;
            cpu.req_ready            <= 1'b0;
            cpu.resp_valid           <= 1'b0;
            cpu.resp_hit             <= 1'b0;
            cpu.resp_err             <= 1'b0;
            mem_req_valid            <= 1'b0;
            mem_req_we               <= MEM_RD;
            mem_req_addr             <= '0;
            clear_selected_valid_bit <= 1'b0;
            finish_new_line_install  <= 1'b0;
            clear_selected_dirty_bit <= 1'b0;
            set_selected_dirty_bit   <= 1'b0;
        end else begin
            clear_selected_valid_bit <= 1'b0;
            finish_new_line_install  <= 1'b0;
            clear_selected_dirty_bit <= 1'b0;
            set_selected_dirty_bit   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu.req_valid && cpu.req_ready) begin
                        we_q          <= cpu.req_we;
                        {tag, set}    <= cpu.req_addr;
                        cpu.req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end else begin
                        cpu.req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (ro_write) begin
                        cpu.resp_valid <= 1'b1;
                        cpu.resp_hit   <= 1'b0;
                        cpu.resp_err   <= 1'b1;
                        state          <= RESPOND;
                    end else if (valid_block_match) begin
                        cpu.resp_valid         <= 1'b1;
                        cpu.resp_hit           <= 1'b1;
                        cpu.resp_err           <= 1'b0;
                        set_selected_dirty_bit <= we_q && !RO;
                        state                  <= RESPOND;
                    end else if (!RO && valid_dirty_bit) begin
                        // Victim address comes from the resident tag, sampled now
                        // while the metadata still points at the old line.
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= MEM_WR;
                        mem_req_addr  <= {selected_tag, set};
                        state         <= WB_REQ;
                    end else begin
                        clear_selected_valid_bit <= 1'b1;
                        mem_req_valid            <= 1'b1;
                        mem_req_we               <= MEM_RD;
                        mem_req_addr             <= {tag, set};
                        state                    <= FILL_REQ;
                    end
                end
                WB_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (mem_resp_valid) begin
                        clear_selected_dirty_bit <= 1'b1;
                        clear_selected_valid_bit <= 1'b1;
                        mem_req_valid            <= 1'b1;
                        mem_req_we               <= MEM_RD;
                        mem_req_addr             <= {tag, set};
                        state                    <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        finish_new_line_install <= 1'b1;
                        set_selected_dirty_bit  <= we_q && !RO;
                        state                   <= INSTALL;
                    end
                end
                INSTALL: begin
                    cpu.resp_valid <= 1'b1;
                    cpu.resp_hit   <= 1'b0;
                    cpu.resp_err   <= 1'b0;
                    state          <= RESPOND;
                end
                RESPOND: begin
                    if (cpu.resp_ready) begin
                        cpu.resp_valid <= 1'b0;
                        cpu.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cache_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk      (clk),
        .reset    (reset),
        .hit_inc  (hit_inc),
        .miss_inc (miss_inc),
        .wb_inc   (wb_inc),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .wb_cnt   (wb_cnt)
    );

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: metadata + memory models around the DUT,
// compared against an abstract direct-mapped write-back cache reference.
module tb_cache_controller;
    import cache_pkg::*;

    localparam int SET_SIZE = 2;
    localparam int TAG_SIZE = 30;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string t, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", t, act, exp);
        end
    endtask

    // ---------------- main DUT (write-back) ----------------
    cache_controller_if #(.ADDR_W(ADDR_W)) cpu ();
    logic [SET_SIZE-1:0] set;
    logic [TAG_SIZE-1:0] tag, sel_tag;
    logic vbm, vdb, clr_v, inst, clr_d, set_d;
    logic mreq_v, mreq_we;
    logic mreq_rdy = 1'b0;
    logic mresp_v  = 1'b0;
    logic [ADDR_W-1:0] mreq_addr;
    logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

    cache_controller #(.NUM_SETS(4), .SET_SIZE(SET_SIZE), .TAG_SIZE(TAG_SIZE),
                       .READ_ONLY(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cpu(cpu), .set(set), .tag(tag),
        .valid_block_match(vbm), .valid_dirty_bit(vdb), .selected_tag(sel_tag),
        .clear_selected_valid_bit(clr_v), .finish_new_line_install(inst),
        .clear_selected_dirty_bit(clr_d), .set_selected_dirty_bit(set_d),
        .mem_req_valid(mreq_v), .mem_req_ready(mreq_rdy), .mem_req_we(mreq_we),
        .mem_req_addr(mreq_addr), .mem_resp_valid(mresp_v),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    // Metadata block: reacts only to the strobes, synchronous reset.
    logic                md_v [4];
    logic                md_d [4];
    logic [TAG_SIZE-1:0] md_t [4];
    assign vbm     = md_v[set] && (md_t[set] == tag);
    assign vdb     = md_v[set] && md_d[set];
    assign sel_tag = md_t[set];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                md_v[i] <= 1'b0; md_d[i] <= 1'b0; md_t[i] <= '0;
            end
        end else begin
            if (clr_v) md_v[set] <= 1'b0;
            if (clr_d) md_d[set] <= 1'b0;
            if (inst) begin md_v[set] <= 1'b1; md_t[set] <= tag; md_d[set] <= 1'b0; end
            if (set_d) md_d[set] <= 1'b1;
        end
    end

    // Strobe pulse counters and memory transaction log.
    int n_clr_v = 0, n_inst = 0, n_clr_d = 0, n_set_d = 0, hs_count = 0;
    logic [ADDR_W:0] mem_log[$];
    always @(posedge clk) begin
        if (clr_v) n_clr_v++;
        if (inst)  n_inst++;
        if (clr_d) n_clr_d++;
        if (set_d) n_set_d++;
        if (mreq_v && mreq_rdy) begin
            mem_log.push_back({mreq_we, mreq_addr});
            hs_count++;
        end
    end

    // Next-level memory: random ready, completion lat_cfg cycles after accept.
    int hs_seen = 0, pend = 0, lat_cfg = 1;
    bit hold_low = 1'b0, spur_en = 1'b0;
    always @(negedge clk) begin
        mresp_v = 1'b0;
        if (hs_count != hs_seen) begin
            hs_seen = hs_count;
            pend    = lat_cfg;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) mresp_v = 1'b1;
        end
        if (spur_en && mreq_v) mresp_v = 1'b1;
        mreq_rdy = hold_low ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // ---------------- read-only DUT, narrow counters ----------------
    cache_controller_if #(.ADDR_W(ADDR_W)) ro_cpu ();
    logic [SET_SIZE-1:0] ro_set;
    logic [TAG_SIZE-1:0] ro_tag;
    logic ro_vbm = 1'b1;
    logic ro_clr_v, ro_inst, ro_clr_d, ro_set_d, ro_mreq_v, ro_mreq_we;
    logic [ADDR_W-1:0] ro_mreq_addr;
    logic [1:0] ro_hit_cnt, ro_miss_cnt, ro_wb_cnt;

    cache_controller #(.NUM_SETS(4), .SET_SIZE(SET_SIZE), .TAG_SIZE(TAG_SIZE),
                       .READ_ONLY(1), .CNT_W(2)) dut_ro (
        .clk(clk), .reset(reset), .cpu(ro_cpu), .set(ro_set), .tag(ro_tag),
        .valid_block_match(ro_vbm), .valid_dirty_bit(1'b0), .selected_tag('0),
        .clear_selected_valid_bit(ro_clr_v), .finish_new_line_install(ro_inst),
        .clear_selected_dirty_bit(ro_clr_d), .set_selected_dirty_bit(ro_set_d),
        .mem_req_valid(ro_mreq_v), .mem_req_ready(1'b1), .mem_req_we(ro_mreq_we),
        .mem_req_addr(ro_mreq_addr), .mem_resp_valid(1'b0),
        .hit_cnt(ro_hit_cnt), .miss_cnt(ro_miss_cnt), .wb_cnt(ro_wb_cnt)
    );

    int n_ro_str = 0;
    always @(posedge clk)
        if (ro_clr_v || ro_inst || ro_clr_d || ro_set_d || ro_mreq_v) n_ro_str++;

    // ---------------- abstract reference cache ----------------
    bit                  g_v [4];
    bit                  g_d [4];
    logic [TAG_SIZE-1:0] g_t [4];
    int e_hit = 0, e_miss = 0, e_wb = 0;

    task automatic ref_reset();
        for (int i = 0; i < 4; i++) begin g_v[i] = 0; g_d[i] = 0; g_t[i] = '0; end
        e_hit = 0; e_miss = 0; e_wb = 0;
    endtask

    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr);
        logic [1:0]          s;
        logic [TAG_SIZE-1:0] t;
        logic [ADDR_W:0]     exp_ops[$];
        logic [ADDR_W:0]     op, prev_bus;
        bit   e_h, did_wb, prev_v;
        int   cyc, c_sd, c_in, c_cv, c_cd, prev_hs, n_exp;
        s = addr[1:0];
        t = addr[ADDR_W-1:2];
        did_wb = 0;
        e_h = g_v[s] && (g_t[s] == t);
        if (e_h) begin
            e_hit++;
            if (we) g_d[s] = 1;
        end else begin
            e_miss++;
            if (g_v[s] && g_d[s]) begin
                exp_ops.push_back({1'b1, g_t[s], s});
                e_wb++;
                did_wb = 1;
            end
            exp_ops.push_back({1'b0, t, s});
            g_v[s] = 1; g_t[s] = t; g_d[s] = we;
        end
        c_sd = n_set_d; c_in = n_inst; c_cv = n_clr_v; c_cd = n_clr_d;

        @(negedge clk);
        cyc = 0;
        while (!cpu.req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        chk("req_ready_wait", cyc < 50, 1);
        cpu.req_valid = 1'b1; cpu.req_we = we; cpu.req_addr = addr;
        @(posedge clk); #1 cpu.req_valid = 1'b0;

        cyc = 0; prev_v = 0; prev_bus = '0; prev_hs = hs_count;
        while (!cpu.resp_valid && cyc < 300) begin
            @(negedge clk); cyc++;
            if (prev_v && hs_count == prev_hs)
                chk("mreq_stable", {mreq_v, mreq_we, mreq_addr}, {1'b1, prev_bus});
            prev_v = mreq_v; prev_bus = {mreq_we, mreq_addr}; prev_hs = hs_count;
        end
        chk("resp_timeout", cyc < 300, 1);
        if (e_h) chk("hit_latency", cyc, 2);
        chk("resp_hit", cpu.resp_hit, e_h);
        chk("resp_err", cpu.resp_err, 0);

        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("resp_hold", {cpu.resp_valid, cpu.resp_hit}, {1'b1, e_h});
        end
        cpu.resp_ready = 1'b1;
        @(posedge clk); #1 cpu.resp_ready = 1'b0;

        n_exp = exp_ops.size();
        chk("mem_ops_count", mem_log.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (mem_log.size() == 0) break;
            op = mem_log.pop_front();
            chk("mem_op", op, exp_ops[i]);
        end
        mem_log.delete();
        chk("set_dirty_pulses", n_set_d - c_sd, we);
        chk("install_pulses", n_inst - c_in, !e_h);
        chk("clr_valid_pulses", n_clr_v - c_cv, !e_h);
        chk("clr_dirty_pulses", n_clr_d - c_cd, did_wb);
        chk("counters", {hit_cnt, miss_cnt, wb_cnt},
            {CNT_W'(e_hit), CNT_W'(e_miss), CNT_W'(e_wb)});
    endtask

    task automatic ro_req(input logic we, input int exp_cnt);
        int cyc, s0;
        s0 = n_ro_str;
        @(negedge clk);
        cyc = 0;
        while (!ro_cpu.req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        ro_cpu.req_valid = 1'b1; ro_cpu.req_we = we; ro_cpu.req_addr = 32'h7;
        @(posedge clk); #1 ro_cpu.req_valid = 1'b0;
        cyc = 0;
        while (!ro_cpu.resp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        chk("ro_resp_latency", cyc, 2);
        chk("ro_resp_err", ro_cpu.resp_err, we);
        chk("ro_resp_hit", ro_cpu.resp_hit, !we);
        ro_cpu.resp_ready = 1'b1;
        @(posedge clk); #1 ro_cpu.resp_ready = 1'b0;
        chk("ro_no_strobes", n_ro_str - s0, 0);
        chk("ro_hit_cnt", ro_hit_cnt, exp_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, hs0, hold_cnt;
        logic [ADDR_W:0] op;
        cpu.req_valid = 0; cpu.req_we = 0; cpu.req_addr = '0; cpu.resp_ready = 0;
        ro_cpu.req_valid = 0; ro_cpu.req_we = 0; ro_cpu.req_addr = '0; ro_cpu.resp_ready = 0;
        ref_reset();

        repeat (3) @(negedge clk);
        chk("rst_ctl", {cpu.req_ready, cpu.resp_valid, mreq_v, clr_v, inst, clr_d, set_d}, 0);
        chk("rst_cnt", {hit_cnt, miss_cnt, wb_cnt}, 0);
        chk("rst_idx", {set, tag}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", cpu.req_ready, 1);

        // Clean read miss then rehit on 0x5 (set 1, tag 1)
        do_req(1'b0, 32'h5);
        do_req(1'b0, 32'h5);
        chk("hit_cnt_after_rehit", hit_cnt, 1);

        // Install {3,2}, write hit, then dirty miss with tag 7 in set 2
        do_req(1'b0, 32'hE);
        do_req(1'b1, 32'hE);
        do_req(1'b1, 32'h1E);
        chk("wb_cnt_after_dirty_miss", wb_cnt, 1);

        // Fill held off ~10 cycles with spurious completions while in FILL_REQ
        hold_low = 1'b1; spur_en = 1'b1; hold_cnt = 0;
        fork
            do_req(1'b0, 32'h24);
            begin
                repeat (12) begin @(negedge clk); if (mreq_v) hold_cnt++; end
                hold_low = 1'b0; spur_en = 1'b0;
            end
        join
        chk("hold_valid_cycles", hold_cnt >= 9, 1);

        // Reset while a fill is outstanding
        do_req(1'b0, 32'hF);
        lat_cfg = 30;
        @(negedge clk);
        cyc = 0;
        while (!cpu.req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        hs0 = hs_count;
        cpu.req_valid = 1'b1; cpu.req_we = 1'b0; cpu.req_addr = 32'h13;
        @(posedge clk); #1 cpu.req_valid = 1'b0;
        cyc = 0;
        while (hs_count == hs0 && cyc < 50) begin @(negedge clk); cyc++; end
        chk("rst_fill_accepted", hs_count - hs0, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1; #1;
        chk("rst_async_ctl", {cpu.req_ready, cpu.resp_valid, mreq_v, clr_v, inst, clr_d, set_d}, 0);
        chk("rst_async_cnt", {hit_cnt, miss_cnt, wb_cnt}, 0);
        chk("rst_async_idx", {set, tag}, 0);
        op = (mem_log.size() != 0) ? mem_log.pop_front() : '1;
        chk("rst_fill_op", op, {1'b0, 32'h13});
        ref_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_no_stale_ops", mem_log.size(), 0);
        lat_cfg = 1;
        do_req(1'b0, 32'hF);
        chk("miss_after_reset", miss_cnt, 1);

        // Random traffic over a small tag space to mix hits, clean and dirty misses
        for (int i = 0; i < 120; i++) begin
            lat_cfg = $urandom_range(1, 4);
            do_req(1'(($urandom_range(0, 1))),
                   {28'(0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
        end

        // Read-only flavour: write errors, hits saturate the 2-bit counter
        ro_req(1'b1, 0);
        ro_req(1'b0, 1);
        ro_req(1'b0, 2);
        ro_req(1'b0, 3);
        ro_req(1'b0, 3);
        chk("ro_miss_wb_cnt", {ro_miss_cnt, ro_wb_cnt}, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
